// File: rtl/vector_pkg.sv
// vector_pkg: shared types and word-format helpers for the vector list builder.
// Contents: 5-bit FSM state enum, bresenham word field offsets,
// header/terminator low-bit patterns and the end-marker test.
package vector_pkg;

    typedef enum logic [4:0] {
        S_RESET      = 5'd0,
        S_SELECT     = 5'd1,
        S_FETCH      = 5'd2,
        S_EVAL       = 5'd3,
        S_TERM       = 5'd4,
        S_DONE       = 5'd5,
        S_WAIT_FRAME = 5'd6
    } state_t;

    // Word layout {x, y, line, pos}; x starts at Y_LSB + OUT_WIDTH.
    localparam int POS_BIT  = 0;
    localparam int LINE_BIT = 1;
    localparam int Y_LSB    = 2;

    // Header and terminator have zero coordinates, so only {line, pos} is stored.
    localparam logic [1:0] HDR_WORD  = 2'b01;
    localparam logic [1:0] TERM_WORD = 2'b11;

    function automatic logic is_end(input logic [1:0] lp);
        return lp[LINE_BIT] & lp[POS_BIT];
    endfunction

endpackage

// File: rtl/vector_translate.sv
// vector_translate: moves a vector point from sprite space to a runtime position.
// Ports: x, y (source point), mid_x, mid_y (sprite mid point),
//        pos_x, pos_y (runtime position), x_out, y_out (translated point, wraps).
module vector_translate #(
    parameter int OUT_WIDTH = 8
) (
    input  logic [OUT_WIDTH-1:0] x,
    input  logic [OUT_WIDTH-1:0] y,
    input  logic [OUT_WIDTH-1:0] mid_x,
    input  logic [OUT_WIDTH-1:0] mid_y,
    input  logic [OUT_WIDTH-1:0] pos_x,
    input  logic [OUT_WIDTH-1:0] pos_y,
    output logic [OUT_WIDTH-1:0] x_out,
    output logic [OUT_WIDTH-1:0] y_out
);

    assign x_out = x - mid_x + pos_x;
    assign y_out = y - mid_y + pos_y;

endmodule

// File: rtl/vector_list_builder.sv
// vector_list_builder: copies enabled vector objects from ROM into the drawing RAM once per frame.
// Ports: clk, rst_n (async active-low); halt (drawer busy, low-then-high requests rebuild);
//        go (list complete); state_debug; dataROM/adrROM (1-cycle-latency ROM);
//        weWRITE/adrWRITE/dataWRITE (RAM write port); obj_* (per-object table, slice i = object i);
//        overflow/runaway (sticky per-frame truncation flags).
module vector_list_builder
    import vector_pkg::*;
#(
    parameter int OUT_WIDTH     = 8,
    parameter int ADR_WIDTH     = 16,
    parameter int DATAWIDTH     = 18,
    parameter int N_OBJ         = 4,
    parameter int RAM_DEPTH     = 4096,
    parameter int MAX_OBJ_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           halt,
    output logic                           go,
    output logic [4:0]                     state_debug,
    input  logic [DATAWIDTH-1:0]           dataROM,
    output logic [ADR_WIDTH-1:0]           adrROM,
    output logic                           weWRITE,
    output logic [ADR_WIDTH-1:0]           adrWRITE,
    output logic [DATAWIDTH-1:0]           dataWRITE,
    input  logic [N_OBJ-1:0]               obj_en,
    input  logic [N_OBJ-1:0]               obj_rel,
    input  logic [N_OBJ*ADR_WIDTH-1:0]     obj_start,
    input  logic [N_OBJ*OUT_WIDTH-1:0]     obj_mid_x,
    input  logic [N_OBJ*OUT_WIDTH-1:0]     obj_mid_y,
    input  logic [N_OBJ*OUT_WIDTH-1:0]     obj_x,
    input  logic [N_OBJ*OUT_WIDTH-1:0]     obj_y,
    output logic                           overflow,
    output logic                           runaway
);

    localparam int IW = $clog2(N_OBJ + 1);
    localparam int CW = $clog2(MAX_OBJ_WORDS + 1);
    localparam int XL = Y_LSB + OUT_WIDTH;
    localparam int NA = 2 ** IW;

    state_t                 state, state_n;
    logic [IW-1:0]          idx, idx_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   go_n, we_n, ovf_n, run_n;
    logic [ADR_WIDTH-1:0]   adr_rom_n, adr_wr_n, wr_next;
    logic [DATAWIDTH-1:0]   data_wr_n, word_out;
    logic [OUT_WIDTH-1:0]   xt, yt;

    // Object table unpacked into power-of-two arrays so the index (which can reach N_OBJ)
    // selects without width mismatch; unused entries read as zero.
    logic                   en_a    [NA];
    logic                   rel_a   [NA];
    logic [ADR_WIDTH-1:0]   start_a [NA];
    logic [OUT_WIDTH-1:0]   mx_a    [NA];
    logic [OUT_WIDTH-1:0]   my_a    [NA];
    logic [OUT_WIDTH-1:0]   px_a    [NA];
    logic [OUT_WIDTH-1:0]   py_a    [NA];

    for (genvar i = 0; i < NA; i++) begin : g_obj
        if (i < N_OBJ) begin : g_v
            assign en_a[i]    = obj_en[i];
            assign rel_a[i]   = obj_rel[i];
            assign start_a[i] = obj_start[i*ADR_WIDTH +: ADR_WIDTH];
            assign mx_a[i]    = obj_mid_x[i*OUT_WIDTH +: OUT_WIDTH];
            assign my_a[i]    = obj_mid_y[i*OUT_WIDTH +: OUT_WIDTH];
            assign px_a[i]    = obj_x[i*OUT_WIDTH +: OUT_WIDTH];
            assign py_a[i]    = obj_y[i*OUT_WIDTH +: OUT_WIDTH];
        end else begin : g_z
            assign en_a[i]    = 1'b0;
            assign rel_a[i]   = 1'b0;
            assign start_a[i] = '0;
            assign mx_a[i]    = '0;
            assign my_a[i]    = '0;
            assign px_a[i]    = '0;
            assign py_a[i]    = '0;
        end
    end

    vector_translate #(.OUT_WIDTH(OUT_WIDTH)) u_translate (
        .x     (dataROM[XL +: OUT_WIDTH]),
        .y     (dataROM[Y_LSB +: OUT_WIDTH]),
        .mid_x (mx_a[idx]),
        .mid_y (my_a[idx]),
        .pos_x (px_a[idx]),
        .pos_y (py_a[idx]),
        .x_out (xt),
        .y_out (yt)
    );

    assign word_out    = rel_a[idx] ? {xt, yt, dataROM[LINE_BIT], dataROM[POS_BIT]} : dataROM;
    assign wr_next     = adrWRITE + 1'b1;
    assign state_debug = state;

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        cnt_n     = cnt;
        we_n      = 1'b0;
        adr_rom_n = adrROM;
        adr_wr_n  = adrWRITE;
        data_wr_n = dataWRITE;
        ovf_n     = overflow;
        run_n     = runaway;
        case (state)
            S_RESET: begin
                ovf_n     = 1'b0;
                run_n     = 1'b0;
                we_n      = 1'b1;
                adr_wr_n  = '0;
                data_wr_n = DATAWIDTH'(HDR_WORD);
                idx_n     = '0;
                state_n   = S_SELECT;
            end
            S_SELECT: begin
                if (idx == IW'(N_OBJ)) begin
                    state_n = S_TERM;
                end else if (!en_a[idx]) begin
                    idx_n = idx + 1'b1;
                end else begin
                    adr_rom_n = start_a[idx];
                    cnt_n     = '0;
                    state_n   = S_FETCH;
                end
            end
            S_FETCH: state_n = S_EVAL;
            S_EVAL: begin
                if (is_end(dataROM[1:0])) begin
                    idx_n   = idx + 1'b1;
                    state_n = S_SELECT;
                end else if (cnt == CW'(MAX_OBJ_WORDS)) begin
                    run_n   = 1'b1;
                    idx_n   = idx + 1'b1;
                    state_n = S_SELECT;
                end else if (wr_next == ADR_WIDTH'(RAM_DEPTH - 1)) begin
                    // Last RAM slot is kept for the terminator.
                    ovf_n   = 1'b1;
                    state_n = S_TERM;
                end else begin
                    we_n      = 1'b1;
                    adr_wr_n  = wr_next;
                    data_wr_n = word_out;
                    adr_rom_n = adrROM + 1'b1;
                    cnt_n     = cnt + 1'b1;
                    state_n   = S_FETCH;
                end
            end
            S_TERM: begin
                we_n      = 1'b1;
                adr_wr_n  = wr_next;
                data_wr_n = DATAWIDTH'(TERM_WORD);
                state_n   = S_DONE;
            end
            S_DONE:       state_n = halt ? S_DONE : S_WAIT_FRAME;
            S_WAIT_FRAME: state_n = halt ? S_RESET : S_WAIT_FRAME;
            default:      state_n = S_RESET;
        endcase
        go_n = (state_n == S_DONE) || (state_n == S_WAIT_FRAME);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RESET;
            idx       <= '0;
            cnt       <= '0;
            go        <= 1'b0;
            weWRITE   <= 1'b0;
            adrROM    <= '0;
            adrWRITE  <= '0;
            dataWRITE <= '0;
            overflow  <= 1'b0;
            runaway   <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            go        <= go_n;
            weWRITE   <= we_n;
            adrROM    <= adr_rom_n;
            adrWRITE  <= adr_wr_n;
            dataWRITE <= data_wr_n;
            overflow  <= ovf_n;
            runaway   <= run_n;
        end
    end

endmodule

// File: tb/tb_vector_list_builder.sv
// tb_vector_list_builder: directed self-checking bench for vector_list_builder with ROM/RAM models.
module tb_vector_list_builder;

    localparam int OW = 8;
    localparam int AW = 16;
    localparam int DW = 18;
    localparam int NO = 4;
    localparam int RD = 12;
    localparam int MW = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               halt = 1'b1;
    logic               go;
    logic [4:0]         state_debug;
    logic [DW-1:0]      dataROM;
    logic [AW-1:0]      adrROM, adrWRITE;
    logic               weWRITE;
    logic [DW-1:0]      dataWRITE;
    logic [NO-1:0]      obj_en, obj_rel;
    logic [NO*AW-1:0]   obj_start;
    logic [NO*OW-1:0]   obj_mid_x, obj_mid_y, obj_x, obj_y;
    logic               overflow, runaway;

    logic [DW-1:0]      rom [256];
    logic [DW-1:0]      ram [64];
    int                 wcount, bad;
    logic               clr = 1'b1;
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 cyc;

    always #5 clk = ~clk;

    vector_list_builder #(
        .OUT_WIDTH(OW), .ADR_WIDTH(AW), .DATAWIDTH(DW), .N_OBJ(NO),
        .RAM_DEPTH(RD), .MAX_OBJ_WORDS(MW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt), .go(go), .state_debug(state_debug),
        .dataROM(dataROM), .adrROM(adrROM), .weWRITE(weWRITE), .adrWRITE(adrWRITE),
        .dataWRITE(dataWRITE), .obj_en(obj_en), .obj_rel(obj_rel), .obj_start(obj_start),
        .obj_mid_x(obj_mid_x), .obj_mid_y(obj_mid_y), .obj_x(obj_x), .obj_y(obj_y),
        .overflow(overflow), .runaway(runaway)
    );

    always @(posedge clk) dataROM <= rom[adrROM[7:0]];

    always @(posedge clk) begin
        if (clr) begin
            wcount <= 0;
            bad    <= 0;
            for (int i = 0; i < 64; i++) ram[i] <= '1;
        end else if (weWRITE) begin
            wcount <= wcount + 1;
            if (adrWRITE >= AW'(RD)) bad <= bad + 1;
            else ram[adrWRITE[5:0]] <= dataWRITE;
        end
    end

    function automatic logic [17:0] w(input logic [7:0] x, input logic [7:0] y, input logic l, input logic p);
        return {x, y, l, p};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_go(output int c);
        c = 0;
        while (go !== 1'b1 && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk("go_rise", go, 1);
        chk("done_state", state_debug, 5);
    endtask

    task automatic clear_ram();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic rebuild(output int c);
        int k;
        clear_ram();
        halt = 1'b0;
        repeat (2) @(negedge clk);
        halt = 1'b1;
        k = 0;
        while (go !== 1'b0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("go_drop", go, 0);
        wait_go(c);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) rom[i] = 18'h3;
        rom[8'h10] = w(8'd1, 8'd2, 1'b0, 1'b0);
        rom[8'h11] = w(8'd3, 8'd4, 1'b1, 1'b0);
        rom[8'h12] = w(8'd200, 8'd100, 1'b0, 1'b1);
        rom[8'h20] = w(8'd10, 8'd2, 1'b1, 1'b0);
        rom[8'h21] = w(8'd0, 8'd0, 1'b0, 1'b0);
        rom[8'h30] = w(8'd5, 8'd6, 1'b0, 1'b1);
        rom[8'h31] = w(8'd7, 8'd8, 1'b1, 1'b0);
        for (int j = 0; j < 4; j++)
            for (int m = 0; m < 4; m++)
                rom[8'h50 + 16*j + m] = w(8'(j*16 + m), 8'(m + 1), 1'b0, 1'b0);
        for (int m = 0; m < 6; m++) rom[8'h90 + m] = w(8'(m), 8'hF0, 1'b0, 1'b1);

        // single object, verbatim copy, built straight out of reset
        obj_en    = 4'b0001;
        obj_rel   = 4'b0000;
        obj_start = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        obj_mid_x = {8'd0, 8'd0, 8'd0, 8'd8};
        obj_mid_y = {8'd0, 8'd0, 8'd0, 8'd8};
        obj_x     = {8'd0, 8'd0, 8'd0, 8'd250};
        obj_y     = {8'd0, 8'd0, 8'd0, 8'd3};
        repeat (3) @(negedge clk);
        clr = 1'b0;
        chk("rst_go", go, 0);
        chk("rst_we", weWRITE, 0);
        chk("rst_adrrom", adrROM, 0);
        chk("rst_adrwr", adrWRITE, 0);
        chk("rst_datawr", dataWRITE, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_run", runaway, 0);
        chk("rst_state", state_debug, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_go(cyc);
        chk("t1_cycles", cyc, 15);
        repeat (2) @(negedge clk);
        chk("t1_ram0", ram[0], 18'h1);
        chk("t1_ram1", ram[1], w(8'd1, 8'd2, 1'b0, 1'b0));
        chk("t1_ram2", ram[2], w(8'd3, 8'd4, 1'b1, 1'b0));
        chk("t1_ram3", ram[3], w(8'd200, 8'd100, 1'b0, 1'b1));
        chk("t1_ram4", ram[4], 18'h3);
        chk("t1_writes", wcount, 5);
        chk("t1_ovf", overflow, 0);
        chk("t1_run", runaway, 0);

        // translation with wrap-around
        obj_rel   = 4'b0001;
        obj_start = {16'h0040, 16'h0030, 16'h0020, 16'h0020};
        rebuild(cyc);
        chk("t2_ram0", ram[0], 18'h1);
        chk("t2_ram1", ram[1], w(8'd252, 8'd253, 1'b1, 1'b0));
        chk("t2_ram2", ram[2], w(8'd242, 8'd251, 1'b0, 1'b0));
        chk("t2_ram3", ram[3], 18'h3);
        chk("t2_writes", wcount, 4);

        // sparse enables: objects 0 and 2 only
        obj_en    = 4'b0101;
        obj_rel   = 4'b0000;
        obj_start = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        rebuild(cyc);
        chk("t3_cycles", cyc, 21);
        chk("t3_ram1", ram[1], w(8'd1, 8'd2, 1'b0, 1'b0));
        chk("t3_ram3", ram[3], w(8'd200, 8'd100, 1'b0, 1'b1));
        chk("t3_ram4", ram[4], w(8'd5, 8'd6, 1'b0, 1'b1));
        chk("t3_ram5", ram[5], w(8'd7, 8'd8, 1'b1, 1'b0));
        chk("t3_ram6", ram[6], 18'h3);
        chk("t3_writes", wcount, 7);

        // RAM overflow: 16 source words into 12 slots
        obj_en    = 4'b1111;
        obj_start = {16'h0080, 16'h0070, 16'h0060, 16'h0050};
        rebuild(cyc);
        chk("t4_ram4", ram[4], w(8'd3, 8'd4, 1'b0, 1'b0));
        chk("t4_ram9", ram[9], w(8'd32, 8'd1, 1'b0, 1'b0));
        chk("t4_ram10", ram[10], w(8'd33, 8'd2, 1'b0, 1'b0));
        chk("t4_ram11", ram[11], 18'h3);
        chk("t4_ram12", ram[12], 18'h3ffff);
        chk("t4_bad", bad, 0);
        chk("t4_writes", wcount, 12);
        chk("t4_ovf", overflow, 1);
        chk("t4_run", runaway, 0);

        // runaway object followed by a normal one
        obj_en    = 4'b0011;
        obj_start = {16'h0040, 16'h0030, 16'h0020, 16'h0090};
        rebuild(cyc);
        chk("t5_ram1", ram[1], w(8'd0, 8'hF0, 1'b0, 1'b1));
        chk("t5_ram4", ram[4], w(8'd3, 8'hF0, 1'b0, 1'b1));
        chk("t5_ram5", ram[5], w(8'd10, 8'd2, 1'b1, 1'b0));
        chk("t5_ram6", ram[6], w(8'd0, 8'd0, 1'b0, 1'b0));
        chk("t5_ram7", ram[7], 18'h3);
        chk("t5_writes", wcount, 8);
        chk("t5_run", runaway, 1);
        chk("t5_ovf", overflow, 0);

        // asynchronous reset in the middle of EVAL
        obj_en    = 4'b0101;
        obj_start = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        clear_ram();
        halt = 1'b0;
        repeat (2) @(negedge clk);
        halt = 1'b1;
        k = 0;
        while (state_debug !== 5'd3 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("t6_reach_eval", state_debug, 3);
        rst_n = 1'b0;
        #1;
        chk("t6_go", go, 0);
        chk("t6_we", weWRITE, 0);
        chk("t6_adrrom", adrROM, 0);
        chk("t6_adrwr", adrWRITE, 0);
        chk("t6_datawr", dataWRITE, 0);
        chk("t6_state", state_debug, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_go(cyc);
        chk("t6_cycles", cyc, 21);
        repeat (2) @(negedge clk);
        rebuild(cyc);
        chk("t6_ram0", ram[0], 18'h1);
        chk("t6_ram2", ram[2], w(8'd3, 8'd4, 1'b1, 1'b0));
        chk("t6_ram5", ram[5], w(8'd7, 8'd8, 1'b1, 1'b0));
        chk("t6_ram6", ram[6], 18'h3);
        chk("t6_writes", wcount, 7);
        chk("t6_ovf", overflow, 0);
        chk("t6_run", runaway, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vector_list_builder.md
Name: vector_list_builder

Overview:
- Parametrised successor of the frame display-list builder.
- Once per frame, copies N_OBJ vector objects from ROM into the drawing RAM, in the bresenham word format {x, y, line, pos}.
- Each object has its own ROM start address, enable, and an optional translation to a runtime position about a mid point.
- Additions over the previous generation: explicit RAM write strobe, RAM-overflow guard and a per-object runaway guard.

Parameters:
- OUT_WIDTH, 8, coordinate width.
- ADR_WIDTH, 16, ROM and RAM address width.
- DATAWIDTH, 18, word width; must equal 2*OUT_WIDTH+2.
- N_OBJ, 4, number of object channels (1..16).
- RAM_DEPTH, 4096, usable RAM words; must be at least 2.
- MAX_OBJ_WORDS, 1024, runaway limit on words read per object.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- halt  in  1  drawer busy flag; a low-then-high sequence requests a rebuild.
- go  out  1  list complete and stable.
- state_debug  out  5  current state encoding.
- dataROM  in  DATAWIDTH  ROM read data; synchronous ROM with 1-cycle latency.
- adrROM  out  ADR_WIDTH  ROM read address.
- weWRITE  out  1  RAM write strobe.
- adrWRITE  out  ADR_WIDTH  RAM write address.
- dataWRITE  out  DATAWIDTH  RAM write data.
- obj_en  in  N_OBJ  object i is drawn this frame.
- obj_rel  in  N_OBJ  1 = translate object i; 0 = copy its coordinates verbatim.
- obj_start  in  N_OBJ*ADR_WIDTH  ROM start address per object; object i occupies slice i.
- obj_mid_x, obj_mid_y  in  N_OBJ*OUT_WIDTH  sprite mid point per object.
- obj_x, obj_y  in  N_OBJ*OUT_WIDTH  runtime position per object.
- overflow  out  1  sticky per frame: the RAM limit truncated the list.
- runaway  out  1  sticky per frame: an object hit MAX_OBJ_WORDS.

Behaviour:
- Reset (asynchronous, rst_n low): state RESET; go, weWRITE, overflow, runaway = 0; adrROM, adrWRITE, dataWRITE = 0; object index = 0.
- All outputs are registered.
- ROM word fields: x=[17:10], y=[9:2], line=[1], pos=[0], generalised by OUT_WIDTH. A word with line=1 and pos=1 is the object end marker and is never copied.
- States and transitions:
  - RESET: clear overflow and runaway; write header {0,0,0,1} to address 0 (weWRITE=1); object index=0 -> SELECT.
  - SELECT:
    - If index = N_OBJ -> TERM.
    - Else if obj_en[index]=0: index++, stay in SELECT. Each skipped object costs one cycle.
    - Else load adrROM = obj_start[index], clear the word counter -> FETCH.
  - FETCH: one wait cycle for ROM latency -> EVAL.
  - EVAL (dataROM is valid):
    - End marker: index++ -> SELECT.
    - Word counter = MAX_OBJ_WORDS: set runaway; index++ -> SELECT; the word is not written.
    - adrWRITE+1 = RAM_DEPTH-1: set overflow -> TERM. The last slot is reserved for the terminator and remaining objects are abandoned.
    - Otherwise: write the word to adrWRITE+1 with weWRITE=1; adrROM++; word counter++ -> FETCH.
  - TERM: write terminator {0,0,1,1} to adrWRITE+1 -> DONE.
  - DONE: go=1; when halt=0 -> WAIT_FRAME.
  - WAIT_FRAME: go=1; when halt=1 -> RESET, with go dropping to 0 in RESET.
- Translation when obj_rel[i]=1: x_out = x - mid_x + obj_x, and likewise y_out. Computed modulo 2^OUT_WIDTH (wrap-around, no clipping). Line and pos bits pass through unchanged.
- weWRITE is high for exactly one cycle per written word, with adrWRITE and dataWRITE valid in that same cycle. It is 0 in all other cycles.
- Throughput: 2 cycles per copied word.
- Object inputs are sampled live. The drawer must hold them stable while go=0.
- rst_n asserted mid-build aborts immediately; the next build starts from the header.
- A frame with no enabled objects writes the header at address 0 and the terminator at address 1.

Decomposition:
- Shared package vector_pkg (extend it) holds:
  - the state enum (5-bit);
  - the word field offsets;
  - the constants HDR_WORD and TERM_WORD;
  - a helper function is_end(word).
- One sub-module, vector_translate: combinational, OUT_WIDTH-parametrised, computes the translated {x_out, y_out}.
- Object-table slice selection stays in the top module.

Test Plan:
- Single object, en=1, rel=0; ROM at start 0x10 holds three words then the end marker -> RAM 0 = {0,0,0,1}, RAM 1..3 = ROM words, RAM 4 = {0,0,1,1}. weWRITE pulses 5 times; go rises 1 cycle after TERM.
- rel=1, mid=(8,8), pos=(250,3), ROM word x=10, y=2 -> written x=252, y=253 (wrap).
- obj_en=4'b0101 -> only objects 0 and 2 are copied, in index order; objects 1 and 3 cost one SELECT cycle each and produce no writes.
- RAM_DEPTH=6 with 10 source words -> words land at addresses 1..4, the terminator at 5, overflow=1, no write at address 6 or above.
- MAX_OBJ_WORDS=4, object with no end marker -> 4 words written, runaway=1, the next object is processed normally.
- Pulse rst_n low during EVAL -> outputs are 0 asynchronously. After release and a halt low-then-high sequence, the full list is rebuilt correctly and overflow/runaway are cleared.
